segre_dcache_writeback: RTL and testbench

- Eviction write buffer on the memory side of the data cache; the opposite direction of the lane-fill path.
- The cache pushes whole dirty lanes with their lane address. The block queues them in a small FIFO and serializes each lane to memory as word-wide beats using a req/gnt handshake.
- While a lane is queued, the block forwards it to the miss path, so a refill never reads stale memory.

---
 rtl/segre_dcache_writeback.sv | 222 ++++++++++++++++++++++
 tb/tb_segre_dcache_writeback.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_writeback.sv
// -----------------------------------------------------------------------------
// segre_dcache_writeback
//
// Eviction write buffer between the data cache and memory. Dirty lanes pushed
// by the cache are queued in a DEPTH-entry FIFO. The head lane is sent to
// memory as LANE_SIZE/WORD_SIZE word beats over a req/gnt handshake. While a
// lane is queued, the miss path can probe the buffer and receive the youngest
// matching copy, so a refill never reads stale memory.
//
// Ports:
//   clk_i, rsn_i                  clock, asynchronous active-low reset
//   evict_valid_i / evict_ready_o push handshake for an evicted lane
//   evict_addr_i, evict_data_i    lane address (offset bits ignored) and data
//   lookup_addr_i                 miss-path probe address
//   lookup_hit_o, lookup_data_o   probe result (data is 0 on a miss)
//   mem_wr_req_o / mem_wr_gnt_i   beat handshake to memory
//   mem_wr_addr_o, mem_wr_data_o  word-aligned beat address and data
//   mem_wr_last_o                 final beat of the current lane
//   empty_o, full_o               buffer occupancy status
// -----------------------------------------------------------------------------
module segre_dcache_writeback #(
  parameter int WORD_SIZE = 32,
  parameter int LANE_SIZE = 128,
  parameter int BYTE_SIZE = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 evict_valid_i,
  output logic                 evict_ready_o,
  input  logic [WORD_SIZE-1:0] evict_addr_i,
  input  logic [LANE_SIZE-1:0] evict_data_i,
  input  logic [WORD_SIZE-1:0] lookup_addr_i,
  output logic                 lookup_hit_o,
  output logic [LANE_SIZE-1:0] lookup_data_o,
  output logic                 mem_wr_req_o,
  output logic [WORD_SIZE-1:0] mem_wr_addr_o,
  output logic [WORD_SIZE-1:0] mem_wr_data_o,
  output logic                 mem_wr_last_o,
  input  logic                 mem_wr_gnt_i,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int BEATS  = LANE_SIZE / WORD_SIZE;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TAG_W  = WORD_SIZE - BYTE_SIZE;
  // Byte-within-word offset bits below the beat index in a beat address.
  localparam int OFF_W  = BYTE_SIZE - BEAT_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Entry storage. Contents need no reset; the valid bits gate visibility.
  logic [TAG_W-1:0]     tag_mem  [DEPTH];
  logic [LANE_SIZE-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]     valid_reg;

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [PTR_W:0]    count_reg;
  logic [PTR_W:0]    count_next;
  state_t            state_reg;
  state_t            state_next;
  logic [BEAT_W-1:0] beat_reg;
  logic [BEAT_W-1:0] beat_next;

  logic push;
  logic pop;
  logic sending;
  logic last_beat;

  logic [TAG_W-1:0]     head_tag;
  logic [LANE_SIZE-1:0] head_data;
  logic [WORD_SIZE-1:0] head_words [BEATS];
  logic [TAG_W-1:0]     lookup_tag;
  logic [DEPTH-1:0]     match;
  logic [PTR_W-1:0]     slot;

  // Lane-offset address bits carry no information for this block.
  logic unused_low_bits;
  assign unused_low_bits = ^{evict_addr_i[BYTE_SIZE-1:0], lookup_addr_i[BYTE_SIZE-1:0]};

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  assign empty_o       = (count_reg == '0);
  assign full_o        = (count_reg == FULL_COUNT);
  // Readiness depends only on registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign evict_ready_o = !full_o;

  assign push      = evict_valid_i && evict_ready_o;
  assign sending   = (state_reg == SEND);
  assign last_beat = (beat_reg == LAST_BEAT);
  assign pop       = sending && mem_wr_gnt_i && last_beat;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat serializer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        // Request is raised from the registered state only, one cycle after
        // the first lane lands in the buffer.
        if (push || count_reg != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (mem_wr_gnt_i) begin
          if (last_beat) begin
            beat_next = '0;
            // Next lane starts immediately when one is waiting.
            if (count_next == '0) begin
              state_next = IDLE;
            end
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      count_reg <= count_next;
      // Head and tail never coincide when both move: a pop needs a non-empty
      // buffer and a push needs a non-full one.
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[tail_reg]  <= evict_addr_i[WORD_SIZE-1:BYTE_SIZE];
      data_mem[tail_reg] <= evict_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory beat outputs
  // ---------------------------------------------------------------------------
  assign head_tag  = tag_mem[head_reg];
  assign head_data = data_mem[head_reg];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_words
      assign head_words[gi] = head_data[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign mem_wr_req_o  = sending;
  assign mem_wr_last_o = sending && last_beat;
  assign mem_wr_addr_o = sending ? {head_tag, beat_reg, {OFF_W{1'b0}}} : '0;
  assign mem_wr_data_o = sending ? head_words[beat_reg] : '0;

  // ---------------------------------------------------------------------------
  // Miss-path forwarding
  // ---------------------------------------------------------------------------
  assign lookup_tag = lookup_addr_i[WORD_SIZE-1:BYTE_SIZE];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_tag);
    end
  endgenerate

  // Walk entries oldest to youngest starting at the head; a later match
  // overrides an earlier one so the youngest copy of a lane is returned.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    slot          = head_reg;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_reg + PTR_W'(i);
      if (match[slot]) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = data_mem[slot];
      end
    end
  end

endmodule

// File: tb/tb_segre_dcache_writeback.sv
module tb_segre_dcache_writeback;

  logic         clk;
  logic         rsn;
  logic         evict_valid;
  logic         ready;
  logic [31:0]  evict_addr;
  logic [127:0] evict_data;
  logic [31:0]  lookup_addr;
  logic         hit;
  logic [127:0] lookup_data;
  logic         req;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         last;
  logic         gnt;
  logic         empty;
  logic         full;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NO_MATCH = 32'hDEAD_0000;

  segre_dcache_writeback #(
    .WORD_SIZE(32),
    .LANE_SIZE(128),
    .BYTE_SIZE(4),
    .DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .evict_valid_i(evict_valid),
    .evict_ready_o(ready),
    .evict_addr_i (evict_addr),
    .evict_data_i (evict_data),
    .lookup_addr_i(lookup_addr),
    .lookup_hit_o (hit),
    .lookup_data_o(lookup_data),
    .mem_wr_req_o (req),
    .mem_wr_addr_o(wr_addr),
    .mem_wr_data_o(wr_data),
    .mem_wr_last_o(last),
    .mem_wr_gnt_i (gnt),
    .empty_o      (empty),
    .full_o       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Lane whose word k holds base address + k.
  function automatic logic [127:0] lane_data(input logic [31:0] a);
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  task automatic test_reset();
    rsn = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    lookup_addr = NO_MATCH; gnt = 1'b0;
    cyc(); cyc();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    rsn = 1'b1;
    cyc();
    $display("reset released");
  endtask

  task automatic test_single_lane();
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    evict_valid = 1'b1; evict_addr = 32'h0000_1040;
    evict_data = 128'h44444444_33333333_22222222_11111111; gnt = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_no_comb_req: got %b expected 0", req); end
    cyc();
    evict_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      exp_addr = 32'h1040 + 32'(4 * b);
      exp_data = 32'h11111111 * 32'(b + 1);
      $display("single beat addr=%h data=%h last=%b", wr_addr, wr_data, last);
      checks++;
      if (req !== 1'b1 || wr_addr !== exp_addr || wr_data !== exp_data || last !== (b == 3)) begin
        errors++;
        $display("FAIL single_beat%0d: got req=%b addr=%h data=%h last=%b expected req=1 addr=%h data=%h last=%b",
                 b, req, wr_addr, wr_data, last, exp_addr, exp_data, (b == 3));
      end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_busy_empty%0d: got %b expected 0", b, empty); end
      cyc();
    end
    gnt = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", empty); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_after: got %b expected 0", req); end
  endtask

  task automatic test_back_pressure();
    int beats;
    int reqs;
    logic [31:0] c_bits;
    beats = 0; reqs = 0;
    evict_valid = 1'b1; evict_addr = 32'h1100; evict_data = lane_data(32'h1100); gnt = 1'b0;
    cyc();
    evict_valid = 1'b0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      c_bits = 32'(c);
      gnt = c_bits[0];
      #1;
      if (req) begin
        reqs++;
        checks++;
        if (wr_addr !== 32'h1100 + 32'(4 * beats) || wr_data !== 32'h1100 + 32'(beats)) begin
          errors++;
          $display("FAIL bp_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                   beats, wr_addr, wr_data, 32'h1100 + 32'(4 * beats), 32'h1100 + 32'(beats));
        end
        if (gnt) begin
          $display("bp beat addr=%h data=%h last=%b", wr_addr, wr_data, last);
          beats++;
        end
      end
      cyc();
    end
    gnt = 1'b0;
    #1;
    checks++; if (reqs !== 8) begin errors++; $display("FAIL bp_req_cycles: got %0d expected 8", reqs); end
    checks++; if (beats !== 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", beats); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req_after: got %b expected 0", req); end
  endtask

  task automatic test_full_wrap();
    int p;
    int beats;
    int gaps;
    int li;
    int b;
    logic [31:0] exp_lane;
    gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evict_valid = 1'b1; evict_addr = 32'(i + 1) * 32'h100; evict_data = lane_data(evict_addr);
      #1;
      checks++;
      if (ready !== (i < 4)) begin errors++; $display("FAIL fw_ready%0d: got %b expected %b", i, ready, (i < 4)); end
      cyc();
    end
    evict_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fw_full: got %b expected 1", full); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fw_not_ready: got %b expected 0", ready); end
    p = 0; beats = 0; gaps = 0;
    for (int c = 0; c < 100 && beats < 28; c++) begin
      gnt = 1'b1;
      evict_valid = (p < 3);
      evict_addr = 32'(p + 6) * 32'h100;
      evict_data = lane_data(evict_addr);
      #1;
      if (!req) begin
        gaps++;
      end else begin
        li = beats / 4; b = beats % 4;
        exp_lane = (li < 4) ? 32'(li + 1) * 32'h100 : 32'(li + 2) * 32'h100;
        $display("fw beat addr=%h data=%h last=%b", wr_addr, wr_data, last);
        checks++;
        if (wr_addr !== exp_lane + 32'(4 * b) || wr_data !== exp_lane + 32'(b) || last !== (b == 3)) begin
          errors++;
          $display("FAIL fw_beat%0d: got addr=%h data=%h last=%b expected addr=%h data=%h last=%b",
                   beats, wr_addr, wr_data, last, exp_lane + 32'(4 * b), exp_lane + 32'(b), (b == 3));
        end
        beats++;
      end
      if (evict_valid && ready) p++;
      cyc();
    end
    evict_valid = 1'b0; gnt = 1'b0;
    #1;
    checks++; if (beats !== 28) begin errors++; $display("FAIL fw_beat_count: got %0d expected 28", beats); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL fw_gaps: got %0d expected 0", gaps); end
    checks++; if (p !== 3) begin errors++; $display("FAIL fw_new_pushes: got %0d expected 3", p); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fw_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_forwarding();
    logic [127:0] lane_a;
    logic [127:0] lane_b;
    logic [31:0]  exp_word;
    int beats;
    lane_a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    lane_b = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    gnt = 1'b0;
    evict_valid = 1'b1; evict_addr = 32'h2000; evict_data = lane_a;
    cyc();
    evict_data = lane_b;
    cyc();
    evict_valid = 1'b0;
    lookup_addr = 32'h2008;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b expected 1", hit); end
    checks++; if (lookup_data !== lane_b) begin errors++; $display("FAIL fwd_youngest: got %h expected %h", lookup_data, lane_b); end
    lookup_addr = 32'h3000;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fwd_miss_hit: got %b expected 0", hit); end
    checks++; if (lookup_data !== 128'h0) begin errors++; $display("FAIL fwd_miss_data: got %h expected 0", lookup_data); end
    lookup_addr = 32'h2008;
    beats = 0;
    cyc();
    for (int c = 0; c < 30 && beats < 8; c++) begin
      gnt = 1'b1;
      #1;
      if (req) begin
        exp_word = (beats < 4) ? lane_a[(beats % 4) * 32 +: 32] : lane_b[(beats % 4) * 32 +: 32];
        $display("fwd beat addr=%h data=%h last=%b", wr_addr, wr_data, last);
        checks++;
        if (wr_addr !== 32'h2000 + 32'(4 * (beats % 4)) || wr_data !== exp_word) begin
          errors++;
          $display("FAIL fwd_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                   beats, wr_addr, wr_data, 32'h2000 + 32'(4 * (beats % 4)), exp_word);
        end
        beats++;
      end
      cyc();
    end
    gnt = 1'b0;
    #1;
    checks++; if (beats !== 8) begin errors++; $display("FAIL fwd_drain: got %0d beats expected 8", beats); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fwd_hit_after_drain: got %b expected 0", hit); end
    lookup_addr = NO_MATCH;
  endtask

  task automatic test_boundary();
    int lanes_done;
    logic [31:0] exp_lane;
    gnt = 1'b0;
    evict_valid = 1'b1; evict_addr = 32'h5000; evict_data = lane_data(32'h5000);
    cyc();
    evict_addr = 32'h5100; evict_data = lane_data(32'h5100);
    cyc();
    evict_valid = 1'b0;
    gnt = 1'b1;
    cyc(); cyc(); cyc();
    // Head is now on its last beat: grant it and push in the same cycle.
    lookup_addr = 32'h5000;
    evict_valid = 1'b1; evict_addr = 32'h5200; evict_data = lane_data(32'h5200);
    #1;
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL bnd_last: got %b expected 1", last); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL bnd_hit_last_beat: got %b expected 1", hit); end
    cyc();
    evict_valid = 1'b0; gnt = 1'b0;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL bnd_hit_after_pop: got %b expected 0", hit); end
    checks++; if (req !== 1'b1 || wr_addr !== 32'h5100) begin errors++; $display("FAIL bnd_next_lane: got req=%b addr=%h expected req=1 addr=00005100", req, wr_addr); end
    checks++; if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL bnd_count2_status: got full=%b empty=%b expected 0 0", full, empty); end
    evict_valid = 1'b1; evict_addr = 32'h5300; evict_data = lane_data(32'h5300);
    cyc();
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL bnd_count3_full: got %b expected 0", full); end
    evict_addr = 32'h5400; evict_data = lane_data(32'h5400);
    cyc();
    evict_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL bnd_count4_full: got %b expected 1", full); end
    lookup_addr = NO_MATCH;
    lanes_done = 0;
    for (int c = 0; c < 60 && lanes_done < 4; c++) begin
      gnt = 1'b1;
      #1;
      if (req && last) begin
        exp_lane = 32'h5100 + 32'(lanes_done) * 32'h100;
        $display("bnd lane done addr=%h data=%h", wr_addr, wr_data);
        checks++;
        if (wr_addr !== exp_lane + 32'hC) begin
          errors++;
          $display("FAIL bnd_order%0d: got %h expected %h", lanes_done, wr_addr, exp_lane + 32'hC);
        end
        lanes_done++;
      end
      cyc();
    end
    gnt = 1'b0;
    #1;
    checks++; if (lanes_done !== 4) begin errors++; $display("FAIL bnd_drain: got %0d lanes expected 4", lanes_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bnd_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    int stray;
    gnt = 1'b0;
    evict_valid = 1'b1; evict_addr = 32'h6000; evict_data = lane_data(32'h6000);
    cyc();
    evict_addr = 32'h6100; evict_data = lane_data(32'h6100);
    cyc();
    evict_valid = 1'b0; gnt = 1'b1;
    cyc(); cyc();
    gnt = 1'b0; lookup_addr = 32'h6000;
    #1;
    checks++; if (wr_addr !== 32'h6008) begin errors++; $display("FAIL rst_mid_beat2: got %h expected 00006008", wr_addr); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_mid_hit_before: got %b expected 1", hit); end
    rsn = 1'b0;
    #1;
    $display("reset asserted mid-transfer");
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", req); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b expected 1", empty); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_mid_hit: got %b expected 0", hit); end
    cyc();
    rsn = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      gnt = 1'b1;
      #1;
      if (req) stray++;
      cyc();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_stray_req: got %0d cycles expected 0", stray); end
    gnt = 1'b0; lookup_addr = NO_MATCH;
    evict_valid = 1'b1; evict_addr = 32'h7000; evict_data = lane_data(32'h7000);
    cyc();
    evict_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || wr_addr !== 32'h7000 || wr_data !== 32'h7000) begin
      errors++; $display("FAIL rst_mid_new_push: got req=%b addr=%h data=%h expected req=1 addr=00007000 data=00007000", req, wr_addr, wr_data);
    end
    gnt = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    gnt = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_final_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    cyc();
    test_back_pressure();
    cyc();
    test_full_wrap();
    cyc();
    test_forwarding();
    cyc();
    test_boundary();
    cyc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
